// File: rtl/debounce_fsm.sv
// -----------------------------------------------------------------------------
// debounce_fsm
// Debounce controller for a raw mechanical switch. The input is synchronised
// into the clk domain, then a new level must persist for STABLE_TICKS
// consecutive ticks of an external timer before it is committed.
//
// Parameters:
//   STABLE_TICKS  ticks a new level must hold before it is accepted (1..255)
//   SYNC_STAGES   flops in the input synchroniser chain (2..4)
//
// Ports:
//   clk       in   system clock, rising edge
//   reset_n   in   asynchronous active-low reset
//   sw_in     in   raw switch level, asynchronous, may bounce
//   tick      in   timer done strobe, only honoured while tick_en=1
//   tick_en   out  timer enable, high while a candidate level is qualifying
//   db_level  out  debounced level
//   db_rise   out  one-cycle strobe on an accepted 0->1 transition
//   db_fall   out  one-cycle strobe on an accepted 1->0 transition
//   busy      out  high while a candidate level is qualifying
// -----------------------------------------------------------------------------
module debounce_fsm #(
   parameter int STABLE_TICKS = 4,
   parameter int SYNC_STAGES  = 2
) (
   input  logic clk,
   input  logic reset_n,
   input  logic sw_in,
   input  logic tick,
   output logic tick_en,
   output logic db_level,
   output logic db_rise,
   output logic db_fall,
   output logic busy
);

   localparam int CW = (STABLE_TICKS > 1) ? $clog2(STABLE_TICKS) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);
   localparam logic [CW-1:0] CNT_INC  = CW'(1);

   typedef enum logic [1:0] {
      ST_ZERO  = 2'd0,
      ST_WAIT1 = 2'd1,
      ST_ONE   = 2'd2,
      ST_WAIT0 = 2'd3
   } state_t;

   state_t                 r_state;
   state_t                 w_state_nxt;
   logic [SYNC_STAGES-1:0] r_sync;
   logic [CW-1:0]          r_cnt;
   logic [CW-1:0]          w_cnt_nxt;
   logic                   w_s;
   logic                   w_cnt_last;
   logic                   r_level;
   logic                   r_rise;
   logic                   r_fall;
   logic                   r_busy;
   logic                   w_level_nxt;
   logic                   w_rise_nxt;
   logic                   w_fall_nxt;
   logic                   w_busy_nxt;

   // Input synchroniser shift chain; only the last stage feeds the FSM.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], sw_in};
      end
   end

   assign w_s        = r_sync[SYNC_STAGES-1];
   assign w_cnt_last = (r_cnt == CNT_LAST);

   // State and tick-counter registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ST_ZERO;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Next-state logic. In WAIT states a reverted input is checked before the
   // tick, so an abort always wins over a completing tick in the same cycle.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         ST_ZERO: begin
            if (w_s) begin
               w_state_nxt = ST_WAIT1;
               w_cnt_nxt   = '0;
            end else begin
               w_state_nxt = ST_ZERO;
            end
         end
         ST_WAIT1: begin
            if (!w_s) begin
               w_state_nxt = ST_ZERO;
            end else if (tick && w_cnt_last) begin
               w_state_nxt = ST_ONE;
            end else if (tick) begin
               w_cnt_nxt = r_cnt + CNT_INC;
            end else begin
               w_state_nxt = ST_WAIT1;
            end
         end
         ST_ONE: begin
            if (!w_s) begin
               w_state_nxt = ST_WAIT0;
               w_cnt_nxt   = '0;
            end else begin
               w_state_nxt = ST_ONE;
            end
         end
         ST_WAIT0: begin
            if (w_s) begin
               w_state_nxt = ST_ONE;
            end else if (tick && w_cnt_last) begin
               w_state_nxt = ST_ZERO;
            end else if (tick) begin
               w_cnt_nxt = r_cnt + CNT_INC;
            end else begin
               w_state_nxt = ST_WAIT0;
            end
         end
         default: begin
            w_state_nxt = ST_ZERO;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   // Output decode from the next state so the registered outputs line up
   // with the state they describe; strobes only on a completed qualification.
   always_comb begin
      w_level_nxt = 1'b0;
      w_busy_nxt  = 1'b0;
      w_rise_nxt  = 1'b0;
      w_fall_nxt  = 1'b0;
      case (w_state_nxt)
         ST_ZERO: begin
            w_fall_nxt = (r_state == ST_WAIT0);
         end
         ST_WAIT1: begin
            w_busy_nxt = 1'b1;
         end
         ST_ONE: begin
            w_level_nxt = 1'b1;
            w_rise_nxt  = (r_state == ST_WAIT1);
         end
         ST_WAIT0: begin
            w_level_nxt = 1'b1;
            w_busy_nxt  = 1'b1;
         end
         default: begin
            w_level_nxt = 1'b0;
            w_busy_nxt  = 1'b0;
         end
      endcase
   end

   // Output registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_level <= 1'b0;
         r_rise  <= 1'b0;
         r_fall  <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         r_level <= w_level_nxt;
         r_rise  <= w_rise_nxt;
         r_fall  <= w_fall_nxt;
         r_busy  <= w_busy_nxt;
      end
   end

   assign db_level = r_level;
   assign db_rise  = r_rise;
   assign db_fall  = r_fall;
   assign busy     = r_busy;
   assign tick_en  = r_busy;

endmodule

// File: tb/tb_debounce_fsm.sv
// -----------------------------------------------------------------------------
// tb_debounce_fsm
// Self-checking bench for debounce_fsm. Instance A uses default parameters,
// instance B uses STABLE_TICKS=1, SYNC_STAGES=3. Both are compared every cycle
// against a level/pending/tick-count reference model.
// -----------------------------------------------------------------------------
module tb_debounce_fsm;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic sw_in = 1'b0;
   logic tick = 1'b0;
   logic tick_en, db_level, db_rise, db_fall, busy;
   logic sw_b = 1'b0;
   logic tick_b = 1'b0;
   logic tick_en_b, db_level_b, db_rise_b, db_fall_b, busy_b;

   int errors = 0;
   int checks = 0;

   debounce_fsm #(.STABLE_TICKS(4), .SYNC_STAGES(2)) dut (
      .clk(clk), .reset_n(reset_n), .sw_in(sw_in), .tick(tick),
      .tick_en(tick_en), .db_level(db_level), .db_rise(db_rise),
      .db_fall(db_fall), .busy(busy)
   );

   debounce_fsm #(.STABLE_TICKS(1), .SYNC_STAGES(3)) dut_b (
      .clk(clk), .reset_n(reset_n), .sw_in(sw_b), .tick(tick_b),
      .tick_en(tick_en_b), .db_level(db_level_b), .db_rise(db_rise_b),
      .db_fall(db_fall_b), .busy(busy_b)
   );

   always #5 clk = ~clk;

   // Reference model: committed level, whether a different level is pending,
   // how many ticks it has survived, and the input delay line.
   typedef struct {
      bit       lvl;
      bit       pend;
      int       nt;
      bit       rise;
      bit       fall;
      bit [3:0] sh;
   } mdl_t;

   mdl_t ma, mb;

   function automatic mdl_t mrst();
      mdl_t m;
      m.lvl = 1'b0; m.pend = 1'b0; m.nt = 0; m.rise = 1'b0; m.fall = 1'b0; m.sh = 4'd0;
      return m;
   endfunction

   function automatic mdl_t mstep(mdl_t m_in, bit sw, bit tk, int st, int ss);
      mdl_t m;
      bit   s;
      m = m_in;
      s = m.sh[ss-1];
      m.sh = {m.sh[2:0], sw};
      m.rise = 1'b0;
      m.fall = 1'b0;
      if (!m.pend) begin
         if (s != m.lvl) begin
            m.pend = 1'b1;
            m.nt = 0;
         end
      end else if (s == m.lvl) begin
         m.pend = 1'b0;
      end else if (tk) begin
         m.nt = m.nt + 1;
         if (m.nt >= st) begin
            m.lvl = s;
            m.pend = 1'b0;
            if (s) m.rise = 1'b1;
            else   m.fall = 1'b1;
         end
      end
      return m;
   endfunction

   // 0: bench timer (tick every 10 enabled cycles), 1: tick_man, 2: random
   int mode = 0;
   bit tick_man = 1'b0;
   bit tick_b_man = 1'b0;
   int tmr = 0;
   int nrise = 0, nfall = 0;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
      end
   endtask

   task automatic cyc();
      case (mode)
         0: tick = tick_en && (tmr == 9);
         1: tick = tick_man;
         2: tick = ($urandom_range(0, 3) == 0);
         default: tick = 1'b0;
      endcase
      tick_b = (mode == 2) ? ($urandom_range(0, 2) == 0) : tick_b_man;
      if (!reset_n || !tick_en) tmr = 0;
      else tmr = (tmr == 9) ? 0 : tmr + 1;
      @(posedge clk);
      if (reset_n) begin
         ma = mstep(ma, sw_in, tick, 4, 2);
         mb = mstep(mb, sw_b, tick_b, 1, 3);
      end else begin
         ma = mrst();
         mb = mrst();
      end
      #1;
      nrise += int'(db_rise);
      nfall += int'(db_fall);
      chk("a_level", db_level, ma.lvl);
      chk("a_busy", busy, ma.pend);
      chk("a_tick_en", tick_en, ma.pend);
      chk("a_rise", db_rise, ma.rise);
      chk("a_fall", db_fall, ma.fall);
      chk("b_level", db_level_b, mb.lvl);
      chk("b_busy", busy_b, mb.pend);
      chk("b_rise", db_rise_b, mb.rise);
      chk("b_fall", db_fall_b, mb.fall);
   endtask

   typedef struct {
      bit sw;
      int cycles;
      bit exp_level;
      bit exp_busy;
      int exp_rise;
      int exp_fall;
   } vec_t;

   initial begin
      vec_t vt[5];
      int   r0, f0, k, first_busy, rise_at, nt;

      // Segments applied from state ONE with the bench timer running.
      vt[0] = '{sw: 1'b0, cycles: 60, exp_level: 1'b0, exp_busy: 1'b0, exp_rise: 0, exp_fall: 1};
      vt[1] = '{sw: 1'b1, cycles: 60, exp_level: 1'b1, exp_busy: 1'b0, exp_rise: 1, exp_fall: 0};
      vt[2] = '{sw: 1'b0, cycles: 20, exp_level: 1'b1, exp_busy: 1'b1, exp_rise: 0, exp_fall: 0};
      vt[3] = '{sw: 1'b1, cycles: 20, exp_level: 1'b1, exp_busy: 1'b0, exp_rise: 0, exp_fall: 0};
      vt[4] = '{sw: 1'b0, cycles: 60, exp_level: 1'b0, exp_busy: 1'b0, exp_rise: 0, exp_fall: 1};

      ma = mrst();
      mb = mrst();
      repeat (3) cyc();
      chk("reset_level", db_level, 0);
      chk("reset_busy", busy, 0);
      chk("reset_rise", db_rise, 0);
      chk("reset_fall", db_fall, 0);
      reset_n = 1'b1;

      // Test 1: step 0->1, busy after 3 cycles, rise after the 4th tick.
      sw_in = 1'b1;
      first_busy = -1;
      rise_at = -1;
      nrise = 0;
      nfall = 0;
      for (k = 1; k <= 60; k++) begin
         cyc();
         if (busy && first_busy < 0) first_busy = k;
         if (db_rise && rise_at < 0) begin
            rise_at = k;
            chk("t1_level_at_rise", db_level, 1);
         end
      end
      chk("t1_busy_cycle", first_busy, 3);
      chk("t1_rise_cycle", rise_at, 43);
      chk("t1_rise_count", nrise, 1);
      chk("t1_fall_count", nfall, 0);

      // Table-driven segments.
      for (int i = 0; i < 5; i++) begin
         r0 = nrise;
         f0 = nfall;
         sw_in = vt[i].sw;
         repeat (vt[i].cycles) cyc();
         chk("tab_level", db_level, vt[i].exp_level);
         chk("tab_busy", busy, vt[i].exp_busy);
         chk("tab_rise", nrise - r0, vt[i].exp_rise);
         chk("tab_fall", nfall - f0, vt[i].exp_fall);
      end

      // Test 2: five toggles at 3-cycle spacing, then settle high.
      r0 = nrise;
      f0 = nfall;
      for (int i = 0; i < 5; i++) begin
         sw_in = ~sw_in;
         repeat (3) cyc();
      end
      chk("t2_no_rise_toggling", nrise - r0, 0);
      repeat (60) cyc();
      chk("t2_rise_count", nrise - r0, 1);
      chk("t2_fall_count", nfall - f0, 0);
      chk("t2_level", db_level, 1);

      // Test 3: fall from ONE, then abort on the 4th tick of a second WAIT0.
      f0 = nfall;
      sw_in = 1'b0;
      repeat (60) cyc();
      chk("t3_fall_count", nfall - f0, 1);
      chk("t3_level_low", db_level, 0);
      sw_in = 1'b1;
      repeat (60) cyc();
      chk("t3_level_high", db_level, 1);
      mode = 1;
      tick_man = 1'b0;
      f0 = nfall;
      sw_in = 1'b0;
      k = 0;
      while (!busy && k < 10) begin
         cyc();
         k++;
      end
      chk("t3_wait0_entered", busy, 1);
      for (int i = 0; i < 3; i++) begin
         tick_man = 1'b1;
         cyc();
         tick_man = 1'b0;
         cyc();
      end
      sw_in = 1'b1;
      cyc();
      cyc();
      tick_man = 1'b1;
      cyc();
      tick_man = 1'b0;
      chk("t3_abort_level", db_level, 1);
      chk("t3_abort_busy", busy, 0);
      chk("t3_abort_fall_now", db_fall, 0);
      repeat (5) cyc();
      chk("t3_abort_no_fall", nfall - f0, 0);

      // Test 4: reset during WAIT1 with two ticks counted.
      mode = 0;
      sw_in = 1'b0;
      repeat (60) cyc();
      sw_in = 1'b1;
      nt = 0;
      k = 0;
      while (nt < 2 && k < 60) begin
         cyc();
         if (tick && ma.pend) nt++;
         k++;
      end
      chk("t4_two_ticks", nt, 2);
      chk("t4_in_wait1", busy, 1);
      #2;
      reset_n = 1'b0;
      #1;
      chk("t4_rst_busy", busy, 0);
      chk("t4_rst_tick_en", tick_en, 0);
      chk("t4_rst_level", db_level, 0);
      chk("t4_rst_rise", db_rise, 0);
      chk("t4_rst_fall", db_fall, 0);
      ma = mrst();
      mb = mrst();
      repeat (2) cyc();
      reset_n = 1'b1;
      r0 = nrise;
      repeat (60) cyc();
      chk("t4_new_rise", nrise - r0, 1);
      chk("t4_level", db_level, 1);

      // Test 5: stale tick held high in ONE and ZERO.
      mode = 1;
      tick_man = 1'b1;
      r0 = nrise;
      f0 = nfall;
      repeat (30) cyc();
      chk("t5_one_level", db_level, 1);
      chk("t5_one_busy", busy, 0);
      mode = 0;
      sw_in = 1'b0;
      repeat (60) cyc();
      f0 = nfall;
      mode = 1;
      repeat (30) cyc();
      chk("t5_zero_level", db_level, 0);
      chk("t5_zero_busy", busy, 0);
      chk("t5_no_strobes", (nrise - r0) + (nfall - f0), 0);
      tick_man = 1'b0;

      // Test 6: STABLE_TICKS=1, SYNC_STAGES=3 instance.
      tick_b_man = 1'b0;
      sw_b = 1'b1;
      repeat (3) cyc();
      chk("t6_busy_cycle3", busy_b, 0);
      cyc();
      chk("t6_busy_cycle4", busy_b, 1);
      tick_b_man = 1'b1;
      cyc();
      tick_b_man = 1'b0;
      chk("t6_rise", db_rise_b, 1);
      chk("t6_level", db_level_b, 1);
      cyc();
      chk("t6_rise_one_cycle", db_rise_b, 0);

      // Random phase: random input bouncing, random ticks, rare resets.
      mode = 2;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 19) == 0) sw_in = ~sw_in;
         if ($urandom_range(0, 9) == 0) sw_b = ~sw_b;
         if ($urandom_range(0, 999) == 0) begin
            reset_n = 1'b0;
            cyc();
            reset_n = 1'b1;
         end
         cyc();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/debounce_fsm.md
Name: debounce_fsm

Overview:
Debounce controller that consumes the one-cycle `done` tick of the parameterised timer. It synchronises a raw mechanical switch input into the clock domain. It then uses the timer tick to require the new level to stay stable for STABLE_TICKS consecutive tick periods before committing it. Outputs are a clean level and one-cycle rise/fall strobes for downstream control logic.

Parameters:
STABLE_TICKS, 4, number of consecutive timer ticks the synchronised input must hold a new level before it is accepted; legal range 1..255.
SYNC_STAGES, 2, flops in the input synchroniser chain; legal range 2..4.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
reset_n  input  1  asynchronous active-low reset.
sw_in  input  1  raw switch/button level, asynchronous to clk, may bounce.
tick  input  1  timer `done` strobe; sampled only while tick_en=1.
tick_en  output  1  drives the timer's `enable`; high only in WAIT states.
db_level  output  1  debounced level.
db_rise  output  1  one-cycle strobe on an accepted 0->1 transition.
db_fall  output  1  one-cycle strobe on an accepted 1->0 transition.
busy  output  1  high while a candidate transition is being qualified (WAIT states).

Behaviour:
- Reset is asynchronous, active-low, on reset_n with clock clk.
- On reset: state ZERO, tick counter 0, all synchroniser flops 0, db_level=0, db_rise=0, db_fall=0, tick_en=0, busy=0.
- Synchroniser: sw_in passes through SYNC_STAGES flops. `s` is the last stage. Latency from sw_in to `s` is SYNC_STAGES cycles. Only `s` is used by the FSM.
- Tick counter: width max(1, $clog2(STABLE_TICKS)). Cleared to 0 on every entry to a WAIT state. Never wraps, because the FSM leaves WAIT when the counter reaches STABLE_TICKS-1 together with a tick.
- States: ZERO, WAIT1, ONE, WAIT0.
- ZERO: if s=1, go to WAIT1 and clear cnt.
- WAIT1:
  - if s=0, go to ZERO (abort, no strobe);
  - else if tick and cnt=STABLE_TICKS-1, go to ONE;
  - else if tick, cnt+1.
- ONE: if s=0, go to WAIT0 and clear cnt.
- WAIT0: symmetric to WAIT1 with polarities swapped; completion goes to ZERO.
- Priority: abort (s reverted) beats a tick arriving in the same cycle. The qualification is discarded and no strobe is issued.
- tick is ignored outside WAIT states. The timer holds `done` high while disabled at its final value, so a stale high tick must have no effect in ZERO/ONE.
- The timer is not cleared by this block. The first tick period after entering WAIT may be partial, so the effective qualification time is between (STABLE_TICKS-1) and STABLE_TICKS full timer periods. This is accepted.
- Outputs are registered, Moore-style.
  - db_level=1 exactly in states ONE and WAIT0.
  - db_rise=1 for exactly the first cycle in ONE after a WAIT1->ONE transition.
  - db_fall=1 for exactly the first cycle in ZERO after a WAIT0->ZERO transition.
  - db_rise and db_fall are never high together, and never high after reset or after an abort.
- tick_en=busy=1 in WAIT1/WAIT0, else 0.
- Reset mid-operation: immediate return to the reset values, regardless of the level of sw_in. A held-high input is then re-qualified from ZERO and produces a fresh db_rise.
- STABLE_TICKS=1: the first tick seen in WAIT completes the transition.

Test Plan:
1. Default params; bench tick pulses every 10 cycles while tick_en=1; sw_in steps 0->1 and holds -> busy rises 3 cycles after the step; db_rise is one cycle high after the 4th tick; db_level=1 from that same cycle; no db_fall.
2. sw_in toggles 5 times, 3-cycle intervals, then settles at 1 -> repeated WAIT1/ZERO aborts with no strobes; exactly one db_rise after 4 ticks of stable 1.
3. From ONE, sw_in drops to 0 and is held -> db_fall one cycle, db_level=0, final state ZERO; then force s back to 1 in the same cycle as the 4th tick during a second WAIT0 -> no db_fall, state ONE.
4. Assert reset_n low during WAIT1 with cnt=2 while sw_in=1 -> all outputs 0 immediately; after release, a full 4-tick qualification and a new db_rise.
5. Hold tick=1 constantly while in ZERO and ONE (stale timer done) -> no state change and no strobes.
6. STABLE_TICKS=1, SYNC_STAGES=3 -> sw_in step reaches busy after 4 cycles; db_rise on the first tick; level changes on the same edge.
